// File: rtl/addsub_multicycle_if.sv
// Start/done handshake and operand/result bundle for the multi-cycle add/sub unit.
interface addsub_multicycle_if #(
   parameter int WIDTH = 20
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b, sub, cin,
      input  ready, done, out, cout, ovf, zero
   );

   modport slave (
      input  start, a, b, sub, cin,
      output ready, done, out, cout, ovf, zero
   );
endinterface

// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock through a registered carry,
// publishing result and flags only when the last chunk completes.
//
// state | meaning
// IDLE  | ready=1, waiting for start; latches operands on accept
// BUSY  | one chunk per edge; last chunk publishes out/flags and pulses done
module addsub_multicycle #(
   parameter int WIDTH = 20,
   parameter int CHUNK = 4
) (
   input logic           clk,
   input logic           rst,
   addsub_multicycle_if.slave bus
);
   localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
   localparam int N          = WIDTH / SAFE_CHUNK;
   localparam int CW         = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_bad_params
         $error("addsub_multicycle: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] out_r;
   logic             carry_r;
   logic             cout_r;
   logic             ovf_r;
   logic             zero_r;
   logic             done_r;
   logic             last;
   logic [CHUNK:0]   sum;
   int               lsb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last      = (cnt == LAST);
      case (state)
         IDLE: if (bus.start) state_nxt = BUSY;
         BUSY: if (last)      state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // Current chunk sum merged into the partial result; intermediate values stay internal.
   always_comb begin
      lsb                 = int'(cnt) * CHUNK;
      sum                 = {1'b0, a_r[lsb +: CHUNK]} + {1'b0, b_r[lsb +: CHUNK]}
                            + (CHUNK + 1)'(carry_r);
      res_nxt             = res_r;
      res_nxt[lsb +: CHUNK] = sum[CHUNK-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         out_r   <= '0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.sub ? ~bus.b : bus.b;
                  carry_r <= bus.sub ? 1'b1 : bus.cin;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               res_r   <= res_nxt;
               carry_r <= sum[CHUNK];
               cnt     <= cnt + 1'b1;
               if (last) begin
                  out_r  <= res_nxt;
                  cout_r <= sum[CHUNK];
                  ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_nxt[WIDTH-1] != a_r[WIDTH-1]);
                  zero_r <= (res_nxt == '0);
                  done_r <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready = (state == IDLE);
   assign bus.done  = done_r;
   assign bus.out   = out_r;
   assign bus.cout  = cout_r;
   assign bus.ovf   = ovf_r;
   assign bus.zero  = zero_r;
endmodule

// File: tb/tb_addsub_multicycle.sv
// Self-checking bench for addsub_multicycle: directed handshake cases plus random ops
// against an arithmetic reference, on CHUNK=4, CHUNK=20 and CHUNK=1 instances.
module tb_addsub_multicycle;
   localparam int W = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cin;
   int           n_asserts = 0;
   int           n_fail    = 0;

   always #5 clk = ~clk;

   addsub_multicycle_if #(.WIDTH(W)) ifd (), if20 (), if1 ();

   assign ifd.start  = start;
   assign ifd.a      = a;
   assign ifd.b      = b;
   assign ifd.sub    = sub;
   assign ifd.cin    = cin;
   assign if20.start = start;
   assign if20.a     = a;
   assign if20.b     = b;
   assign if20.sub   = sub;
   assign if20.cin   = cin;
   assign if1.start  = start;
   assign if1.a      = a;
   assign if1.b      = b;
   assign if1.sub    = sub;
   assign if1.cin    = cin;

   addsub_multicycle #(.WIDTH(W), .CHUNK(4))  dut    (.clk(clk), .rst(rst), .bus(ifd.slave));
   addsub_multicycle #(.WIDTH(W), .CHUNK(20)) dut_c20 (.clk(clk), .rst(rst), .bus(if20.slave));
   addsub_multicycle #(.WIDTH(W), .CHUNK(1))  dut_c1  (.clk(clk), .rst(rst), .bus(if1.slave));

   // Reference: {cout, ovf, zero, out} from plain integer arithmetic.
   function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic ms, input logic mc);
      logic [W-1:0] bb;
      logic         c;
      logic [W:0]   s;
      longint       sa, sb, st;
      logic         v;
      bb = ms ? ~mb : mb;
      c  = ms ? 1'b1 : mc;
      s  = {1'b0, ma} + {1'b0, bb} + (W + 1)'(c);
      sa = ma[W-1] ? longint'(ma) - (longint'(1) << W) : longint'(ma);
      sb = bb[W-1] ? longint'(bb) - (longint'(1) << W) : longint'(bb);
      st = sa + sb + longint'(c);
      v  = (st > (longint'(1) << (W - 1)) - 1) || (st < -(longint'(1) << (W - 1)));
      return {s[W], v, (s[W-1:0] == '0), s[W-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Runs one op on the CHUNK=4 instance; optional start injection while busy at
   // loop index inj; pulse=1 also checks the cycle after done.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc, input int inj, input bit pulse);
      logic [W+2:0] expv;
      logic [W-1:0] prev;
      int           g, lat, low;
      bit           stable;
      expv = model(ta, tb_, ts, tc);
      g = 0;
      while (!ifd.ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk({tag, " ready_before"}, 64'(ifd.ready), 64'd1);
      prev  = ifd.out;
      a     = ta;
      b     = tb_;
      sub   = ts;
      cin   = tc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      lat = 0;
      low = 0;
      stable = 1'b1;
      while (!ifd.done && lat < 40) begin
         if (!ifd.ready) low++;
         if (ifd.out !== prev) stable = 1'b0;
         if (inj > 0 && lat == inj) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'd5);
      chk({tag, " ready_low"}, 64'(low), 64'd5);
      chk({tag, " out_held"}, 64'(stable), 64'd1);
      chk({tag, " result"}, 64'({ifd.cout, ifd.ovf, ifd.zero, ifd.out}), 64'(expv));
      if (pulse) begin
         @(negedge clk);
         chk({tag, " done_pulse"}, 64'(ifd.done), 64'd0);
         chk({tag, " ready_after"}, 64'(ifd.ready), 64'd1);
      end
   endtask

   // Same op on all three instances; checks each latency and result.
   task automatic run_multi(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic ts, input logic tc);
      logic [W+2:0] expv, r4, r20, r1;
      int           g, l4, l20, l1;
      expv = model(ta, tb_, ts, tc);
      g = 0;
      while (!(ifd.ready && if20.ready && if1.ready) && g < 60) begin
         @(negedge clk);
         g++;
      end
      a     = ta;
      b     = tb_;
      sub   = ts;
      cin   = tc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l4 = -1; l20 = -1; l1 = -1;
      r4 = '0; r20 = '0; r1 = '0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         if (ifd.done && l4 < 0) begin
            l4 = cyc;
            r4 = {ifd.cout, ifd.ovf, ifd.zero, ifd.out};
         end
         if (if20.done && l20 < 0) begin
            l20 = cyc;
            r20 = {if20.cout, if20.ovf, if20.zero, if20.out};
         end
         if (if1.done && l1 < 0) begin
            l1 = cyc;
            r1 = {if1.cout, if1.ovf, if1.zero, if1.out};
         end
         @(negedge clk);
      end
      chk({tag, " c4_latency"}, 64'(l4), 64'd5);
      chk({tag, " c20_latency"}, 64'(l20), 64'd1);
      chk({tag, " c1_latency"}, 64'(l1), 64'd20);
      chk({tag, " c4_result"}, 64'(r4), 64'(expv));
      chk({tag, " c20_result"}, 64'(r20), 64'(expv));
      chk({tag, " c1_result"}, 64'(r1), 64'(expv));
   endtask

   initial begin
      int nd, g;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sub   = 1'b0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ready", 64'(ifd.ready), 64'd1);
      chk("reset done", 64'(ifd.done), 64'd0);
      chk("reset outputs", 64'({ifd.cout, ifd.ovf, ifd.zero, ifd.out}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("add_basic", 20'h12345, 20'h00001, 1'b0, 1'b0, 0, 1'b1);
      chk("add_basic const", 64'(ifd.out), 64'h12346);
      run_op("add_wrap", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 0, 1'b1);
      chk("add_wrap const", 64'({ifd.cout, ifd.zero, ifd.out}), 64'({2'b11, 20'h00000}));
      run_op("add_cin", 20'hFFFFF, 20'h00000, 1'b0, 1'b1, 0, 1'b1);
      run_op("add_ovf", 20'h7FFFF, 20'h00001, 1'b0, 1'b0, 0, 1'b1);
      chk("add_ovf const", 64'({ifd.cout, ifd.ovf, ifd.out}), 64'({2'b01, 20'h80000}));
      run_op("sub_ovf", 20'h80000, 20'h00001, 1'b1, 1'b0, 0, 1'b1);
      chk("sub_ovf const", 64'({ifd.cout, ifd.ovf, ifd.out}), 64'({2'b11, 20'h7FFFF}));
      run_op("sub_neg", 20'h00005, 20'h00007, 1'b1, 1'b1, 0, 1'b1);
      chk("sub_neg const", 64'({ifd.cout, ifd.ovf, ifd.out}), 64'({2'b00, 20'hFFFFE}));

      run_op("busy_start", 20'h11111, 20'h22222, 1'b0, 1'b0, 2, 1'b1);
      run_op("hold_first", 20'h00100, 20'h00200, 1'b0, 1'b0, 0, 1'b0);
      chk("hold_first done", 64'(ifd.done), 64'd1);
      run_op("hold_second", 20'h00010, 20'h00020, 1'b0, 1'b0, 0, 1'b1);
      chk("hold_second const", 64'(ifd.out), 64'h00030);

      g = 0;
      while (!ifd.ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      a     = 20'h0ABCD;
      b     = 20'h01234;
      sub   = 1'b0;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst ready", 64'(ifd.ready), 64'd1);
      chk("midrst done", 64'(ifd.done), 64'd0);
      chk("midrst outputs", 64'({ifd.cout, ifd.ovf, ifd.zero, ifd.out}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifd.done) nd++;
      end
      chk("midrst no_done", 64'(nd), 64'd0);
      run_op("after_rst", 20'h0ABCD, 20'h01234, 1'b0, 1'b0, 0, 1'b1);

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                1'($urandom), 1'($urandom), 0, 1'b1);
      end

      run_multi("m_add_ovf", 20'h7FFFF, 20'h00001, 1'b0, 1'b0);
      run_multi("m_sub_ovf", 20'h80000, 20'h00001, 1'b1, 1'b0);
      run_multi("m_add_wrap", 20'hFFFFF, 20'h00001, 1'b0, 1'b0);
      run_multi("m_add_basic", 20'h12345, 20'h00001, 1'b0, 1'b0);
      run_multi("m_sub_neg", 20'h00005, 20'h00007, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         run_multi($sformatf("m_rand%0d", i), W'($urandom), W'($urandom),
                   1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
